// File: rtl/nec_bus_pkg.sv
// Shared types and helpers for the NEC V30 bus responder.
package nec_bus_pkg;

   localparam int AD_W = 20;
   localparam int D_W  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      REQ  = 2'd2,
      RESP = 2'd3
   } state_t;

   // Byte enables {hi, lo}: the high byte follows UBEn, the low byte follows A0.
   function automatic logic [1:0] be_from(input logic ube_n, input logic a0);
      return {~ube_n, ~a0};
   endfunction

endpackage

// File: rtl/nec_bus_sync.sv
// Input register stage for the NEC pins plus edge detection on the
// registered copies. The INTAK falling-edge output only exists when
// NEC_INTA_VECTOR_EN is defined.
module nec_bus_sync
   import nec_bus_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic [AD_W-1:0] pin_ad,
   input  logic            pin_astb,
   input  logic            pin_rd_n,
   input  logic            pin_wr_n,
   input  logic            pin_io_n,
   input  logic            pin_ube_n,
   input  logic            pin_intak_n,
   output logic [AD_W-1:0] ad,
   output logic            rd_n,
   output logic            wr_n,
   output logic            io_n,
   output logic            ube_n,
   output logic            intak_n,
   output logic            astb_rise,
   output logic            rd_fall,
   output logic            wr_fall
`ifdef NEC_INTA_VECTOR_EN
   ,
   output logic            intak_fall
`endif
);

   logic astb;
   logic astb_d;
   logic rd_n_d;
   logic wr_n_d;

   // Register every pin once, then keep a delayed copy of the strobes for edges.
   always_ff @(posedge clk) begin
      if (reset) begin
         ad      <= '0;
         astb    <= 1'b0;
         rd_n    <= 1'b1;
         wr_n    <= 1'b1;
         io_n    <= 1'b1;
         ube_n   <= 1'b1;
         intak_n <= 1'b1;
         astb_d  <= 1'b0;
         rd_n_d  <= 1'b1;
         wr_n_d  <= 1'b1;
      end else begin
         ad      <= pin_ad;
         astb    <= pin_astb;
         rd_n    <= pin_rd_n;
         wr_n    <= pin_wr_n;
         io_n    <= pin_io_n;
         ube_n   <= pin_ube_n;
         intak_n <= pin_intak_n;
         astb_d  <= astb;
         rd_n_d  <= rd_n;
         wr_n_d  <= wr_n;
      end
   end

   assign astb_rise = astb & ~astb_d;
   assign rd_fall   = ~rd_n & rd_n_d;
   assign wr_fall   = ~wr_n & wr_n_d;

`ifdef NEC_INTA_VECTOR_EN
   logic intak_n_d;

   // Delayed INTAK copy, only needed for the vector-return cycle.
   always_ff @(posedge clk) begin
      if (reset) intak_n_d <= 1'b1;
      else       intak_n_d <= intak_n;
   end

   assign intak_fall = ~intak_n & intak_n_d;
`endif

endmodule

// File: rtl/nec_bus_responder.sv
// Bus-slave responder for the NEC V30 pin interface.
// States:
//   state | meaning
//   IDLE  | no CPU cycle in progress, READY high
//   ADDR  | address latched, waiting for RDn/WRn (or INTAKn)
//   REQ   | bus_req outstanding, waiting for bus_ack or timeout
//   RESP  | request done, READY high, waiting for strobes to return high
// Optional feature macro: NEC_INTA_VECTOR_EN (INTAK returns int_vector on AD).
module nec_bus_responder
   import nec_bus_pkg::*;
#(
   parameter int             TIMEOUT_CYCLES = 1024,
   parameter logic [D_W-1:0] OPEN_BUS_DATA  = 16'hFFFF
)
(
   input  logic            clk,
   input  logic            reset,
   input  logic [AD_W-1:0] nec_ad_in,
   output logic [D_W-1:0]  nec_ad_out,
   output logic            nec_ad_oe,
   input  logic            nec_astb,
   input  logic            nec_rd_n,
   input  logic            nec_wr_n,
   input  logic            nec_io_n,
   input  logic            nec_ube_n,
   input  logic            nec_intak_n,
   output logic            nec_ready,
   output logic            bus_req,
   output logic [AD_W-1:0] bus_addr,
   output logic            bus_io,
   output logic            bus_we,
   output logic [1:0]      bus_be,
   output logic [D_W-1:0]  bus_wdata,
   input  logic            bus_ack,
   input  logic [D_W-1:0]  bus_rdata,
   output logic            bus_timeout,
   output logic            proto_err
`ifdef NEC_INTA_VECTOR_EN
   ,
   input  logic [7:0]      int_vector
`endif
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [AD_W-1:0] ad;
   logic            rd_n, wr_n, io_n, ube_n, intak_n;
   logic            astb_rise, rd_fall, wr_fall;
`ifdef NEC_INTA_VECTOR_EN
   logic            intak_fall;
`endif

   nec_bus_sync u_sync (
      .clk         (clk),
      .reset       (reset),
      .pin_ad      (nec_ad_in),
      .pin_astb    (nec_astb),
      .pin_rd_n    (nec_rd_n),
      .pin_wr_n    (nec_wr_n),
      .pin_io_n    (nec_io_n),
      .pin_ube_n   (nec_ube_n),
      .pin_intak_n (nec_intak_n),
      .ad          (ad),
      .rd_n        (rd_n),
      .wr_n        (wr_n),
      .io_n        (io_n),
      .ube_n       (ube_n),
      .intak_n     (intak_n),
      .astb_rise   (astb_rise),
      .rd_fall     (rd_fall),
      .wr_fall     (wr_fall)
`ifdef NEC_INTA_VECTOR_EN
      ,
      .intak_fall  (intak_fall)
`endif
   );

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [AD_W-1:0]  addr_nxt;
   logic [D_W-1:0]   wdata_nxt, ad_out_nxt;
   logic [1:0]       be_nxt;
   logic             io_nxt, we_nxt, req_nxt, ready_nxt, oe_nxt, timeout_nxt, perr_nxt;
   logic             both_low, resp_done;

   assign both_low = ~rd_n & ~wr_n;
`ifdef NEC_INTA_VECTOR_EN
   assign resp_done = rd_n & wr_n & intak_n;
`else
   assign resp_done = rd_n & wr_n;
`endif

   // Next-state and next-output decode; a fresh ASTB always restarts the cycle.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      addr_nxt    = bus_addr;
      io_nxt      = bus_io;
      we_nxt      = bus_we;
      be_nxt      = bus_be;
      wdata_nxt   = bus_wdata;
      req_nxt     = bus_req;
      ready_nxt   = nec_ready;
      oe_nxt      = nec_ad_oe;
      ad_out_nxt  = nec_ad_out;
      timeout_nxt = 1'b0;
      perr_nxt    = 1'b0;
      if (state == REQ && cnt != '0) cnt_nxt = cnt - 1'b1;

      if (astb_rise) begin
         addr_nxt  = ad;
         io_nxt    = ~io_n;
         be_nxt    = be_from(ube_n, ad[0]);
         ready_nxt = 1'b0;
         req_nxt   = 1'b0;
         oe_nxt    = 1'b0;
         perr_nxt  = (state != IDLE);
         state_nxt = ADDR;
      end else begin
         case (state)
            ADDR: begin
`ifdef NEC_INTA_VECTOR_EN
               if (intak_fall) begin
                  ad_out_nxt = {8'h00, int_vector};
                  oe_nxt     = 1'b1;
                  ready_nxt  = 1'b1;
                  state_nxt  = RESP;
               end else
`else
               if (~intak_n) begin
                  ready_nxt = 1'b1;
                  state_nxt = IDLE;
               end else
`endif
               if (rd_fall || wr_fall) begin
                  // Both strobes low is a CPU protocol fault; serve it as a read.
                  we_nxt    = wr_fall & ~both_low;
                  if (wr_fall && !both_low) wdata_nxt = ad[D_W-1:0];
                  perr_nxt  = both_low;
                  req_nxt   = 1'b1;
                  cnt_nxt   = CNT_LOAD;
                  state_nxt = REQ;
               end
            end
            REQ: begin
               if (bus_ack) begin
                  req_nxt   = 1'b0;
                  ready_nxt = 1'b1;
                  if (!bus_we) begin
                     ad_out_nxt = bus_rdata;
                     oe_nxt     = 1'b1;
                  end
                  state_nxt = RESP;
               end else if (cnt == '0) begin
                  timeout_nxt = 1'b1;
                  req_nxt     = 1'b0;
                  ready_nxt   = 1'b1;
                  if (!bus_we) begin
                     ad_out_nxt = OPEN_BUS_DATA;
                     oe_nxt     = 1'b1;
                  end
                  state_nxt = RESP;
               end
            end
            RESP: begin
               if (resp_done) begin
                  oe_nxt    = 1'b0;
                  state_nxt = IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         bus_addr    <= '0;
         bus_io      <= 1'b0;
         bus_we      <= 1'b0;
         bus_be      <= 2'b00;
         bus_wdata   <= '0;
         bus_req     <= 1'b0;
         nec_ready   <= 1'b1;
         nec_ad_oe   <= 1'b0;
         nec_ad_out  <= '0;
         bus_timeout <= 1'b0;
         proto_err   <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         bus_addr    <= addr_nxt;
         bus_io      <= io_nxt;
         bus_we      <= we_nxt;
         bus_be      <= be_nxt;
         bus_wdata   <= wdata_nxt;
         bus_req     <= req_nxt;
         nec_ready   <= ready_nxt;
         nec_ad_oe   <= oe_nxt;
         nec_ad_out  <= ad_out_nxt;
         bus_timeout <= timeout_nxt;
         proto_err   <= perr_nxt;
      end
   end

endmodule

// File: tb/tb_nec_bus_responder.sv
// Scoreboard bench for nec_bus_responder: stimulus pushes expected
// requests/responses, monitors pop and compare on bus_req / READY rise.
module tb_nec_bus_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [19:0] nec_ad_in = '0;
   logic [15:0] nec_ad_out;
   logic        nec_ad_oe;
   logic        nec_astb = 1'b0;
   logic        nec_rd_n = 1'b1;
   logic        nec_wr_n = 1'b1;
   logic        nec_io_n = 1'b1;
   logic        nec_ube_n = 1'b1;
   logic        nec_intak_n = 1'b1;
   logic        nec_ready;
   logic        bus_req;
   logic [19:0] bus_addr;
   logic        bus_io;
   logic        bus_we;
   logic [1:0]  bus_be;
   logic [15:0] bus_wdata;
   logic        bus_ack = 1'b0;
   logic [15:0] bus_rdata = '0;
   logic        bus_timeout;
   logic        proto_err;
`ifdef NEC_INTA_VECTOR_EN
   logic [7:0]  int_vector = 8'h00;
`endif

   nec_bus_responder #(.TIMEOUT_CYCLES(16), .OPEN_BUS_DATA(16'hFFFF)) dut (
      .clk         (clk),
      .reset       (reset),
      .nec_ad_in   (nec_ad_in),
      .nec_ad_out  (nec_ad_out),
      .nec_ad_oe   (nec_ad_oe),
      .nec_astb    (nec_astb),
      .nec_rd_n    (nec_rd_n),
      .nec_wr_n    (nec_wr_n),
      .nec_io_n    (nec_io_n),
      .nec_ube_n   (nec_ube_n),
      .nec_intak_n (nec_intak_n),
      .nec_ready   (nec_ready),
      .bus_req     (bus_req),
      .bus_addr    (bus_addr),
      .bus_io      (bus_io),
      .bus_we      (bus_we),
      .bus_be      (bus_be),
      .bus_wdata   (bus_wdata),
      .bus_ack     (bus_ack),
      .bus_rdata   (bus_rdata),
      .bus_timeout (bus_timeout),
      .proto_err   (proto_err)
`ifdef NEC_INTA_VECTOR_EN
      ,
      .int_vector  (int_vector)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [19:0] addr;
      logic        io;
      logic        we;
      logic [1:0]  be;
      logic [15:0] wdata;
   } req_t;

   typedef struct {
      logic        oe;
      logic        chk_data;
      logic [15:0] data;
      logic        to;
   } resp_t;

   req_t  exp_req[$];
   resp_t exp_resp[$];

   int checks = 0;
   int errors = 0;
   int perr_cnt = 0;
   int to_cnt = 0;
   bit mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_req(input logic [19:0] a, input logic io, input logic we,
                           input logic [1:0] be, input logic [15:0] wd);
      req_t r;
      r.addr = a; r.io = io; r.we = we; r.be = be; r.wdata = wd;
      exp_req.push_back(r);
   endtask

   task automatic push_resp(input logic oe, input logic cd, input logic [15:0] d, input logic to);
      resp_t r;
      r.oe = oe; r.chk_data = cd; r.data = d; r.to = to;
      exp_resp.push_back(r);
   endtask

   // Monitor: compare against the scoreboard on each new request and each READY rise.
   initial begin
      logic req_q, ready_q;
      req_t  r;
      resp_t p;
      req_q = 1'b0;
      ready_q = 1'b1;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (bus_req && !req_q) begin
               if (exp_req.size() == 0) begin
                  chk("unexpected_req", 32'(bus_addr), 32'hFFFFFFFF);
               end else begin
                  r = exp_req.pop_front();
                  chk("req_addr", 32'(bus_addr), 32'(r.addr));
                  chk("req_io", 32'(bus_io), 32'(r.io));
                  chk("req_we", 32'(bus_we), 32'(r.we));
                  chk("req_be", 32'(bus_be), 32'(r.be));
                  if (r.we) chk("req_wdata", 32'(bus_wdata), 32'(r.wdata));
               end
            end
            if (nec_ready && !ready_q) begin
               if (exp_resp.size() == 0) begin
                  chk("unexpected_ready", 32'(nec_ad_out), 32'hFFFFFFFF);
               end else begin
                  p = exp_resp.pop_front();
                  chk("resp_oe", 32'(nec_ad_oe), 32'(p.oe));
                  chk("resp_timeout", 32'(bus_timeout), 32'(p.to));
                  if (p.chk_data) chk("resp_data", 32'(nec_ad_out), 32'(p.data));
               end
            end
            if (proto_err) perr_cnt++;
            if (bus_timeout) to_cnt++;
         end
         req_q = bus_req;
         ready_q = nec_ready;
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   // ASTB pulse with address; returns two negedges later when READY should be low.
   task automatic cpu_addr(input logic [19:0] a, input logic io_n, input logic ube_n);
      nec_ad_in = a;
      nec_io_n  = io_n;
      nec_ube_n = ube_n;
      nec_astb  = 1'b1;
      tick();
      nec_astb = 1'b0;
      tick();
   endtask

   task automatic wait_req();
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus_req) break;
      end
      chk("wait_req", 32'(bus_req), 32'd1);
   endtask

   task automatic ack(input logic [15:0] d);
      bus_ack   = 1'b1;
      bus_rdata = d;
      tick();
      bus_ack = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      chk("rst_ready", 32'(nec_ready), 32'd1);
      chk("rst_oe", 32'(nec_ad_oe), 32'd0);
      chk("rst_ad_out", 32'(nec_ad_out), 32'd0);
      chk("rst_req", 32'(bus_req), 32'd0);
      chk("rst_addr", 32'(bus_addr), 32'd0);
      chk("rst_be_io_we", 32'({bus_be, bus_io, bus_we}), 32'd0);
      chk("rst_wdata", 32'(bus_wdata), 32'd0);
      chk("rst_pulses", 32'({bus_timeout, proto_err}), 32'd0);
      reset = 1'b0;
      tick();
      mon_en = 1'b1;

      // Memory word read, ack after 5 clk.
      push_req(20'h12344, 1'b0, 1'b0, 2'b11, 16'h0000);
      push_resp(1'b1, 1'b1, 16'hBEEF, 1'b0);
      cpu_addr(20'h12344, 1'b1, 1'b0);
      chk("rd_ready_low_t2", 32'(nec_ready), 32'd0);
      nec_rd_n = 1'b0;
      wait_req();
      for (int i = 0; i < 5; i++) begin
         chk("rd_ready_held_low", 32'(nec_ready), 32'd0);
         tick();
      end
      ack(16'hBEEF);
      tick();
      chk("rd_oe_hold", 32'(nec_ad_oe), 32'd1);
      chk("rd_data_hold", 32'(nec_ad_out), 32'hBEEF);
      nec_rd_n = 1'b1;
      tick();
      tick();
      chk("rd_oe_drop", 32'(nec_ad_oe), 32'd0);
      chk("rd_data_after", 32'(nec_ad_out), 32'hBEEF);

      // IO byte write to odd port.
      push_req(20'h00081, 1'b1, 1'b1, 2'b10, 16'h5A00);
      push_resp(1'b0, 1'b0, 16'h0000, 1'b0);
      cpu_addr(20'h00081, 1'b0, 1'b0);
      nec_ad_in = 20'h05A00;
      nec_wr_n  = 1'b0;
      wait_req();
      tick();
      ack(16'h0000);
      chk("wr_ready_on_ack", 32'(nec_ready), 32'd1);
      nec_wr_n = 1'b1;
      tick();
      tick();

      // Read with no ack: timeout 16 clk after req rises.
      push_req(20'h00100, 1'b0, 1'b0, 2'b01, 16'h0000);
      push_resp(1'b1, 1'b1, 16'hFFFF, 1'b1);
      cpu_addr(20'h00100, 1'b1, 1'b1);
      nec_rd_n = 1'b0;
      wait_req();
      repeat (15) tick();
      chk("to_not_early", 32'({bus_timeout, bus_req}), 32'b01);
      tick();
      chk("to_pulse", 32'({bus_timeout, bus_req, nec_ready}), 32'b101);
      tick();
      chk("to_one_cycle", 32'(bus_timeout), 32'd0);
      nec_rd_n = 1'b1;
      tick();
      tick();

      // Ack in the timeout cycle: ack wins.
      push_req(20'h00102, 1'b0, 1'b0, 2'b11, 16'h0000);
      push_resp(1'b1, 1'b1, 16'h1234, 1'b0);
      cpu_addr(20'h00102, 1'b1, 1'b0);
      nec_rd_n = 1'b0;
      wait_req();
      repeat (15) tick();
      ack(16'h1234);
      chk("coinc_no_timeout", 32'(bus_timeout), 32'd0);
      nec_rd_n = 1'b1;
      tick();
      tick();

      // Second ASTB while in REQ; stale ack ignored, new request served.
      push_req(20'h00200, 1'b0, 1'b0, 2'b11, 16'h0000);
      cpu_addr(20'h00200, 1'b1, 1'b0);
      nec_rd_n = 1'b0;
      wait_req();
      nec_rd_n  = 1'b1;
      nec_ad_in = 20'h00300;
      nec_astb  = 1'b1;
      tick();
      nec_astb = 1'b0;
      tick();
      chk("perr_pulse", 32'({proto_err, bus_req, nec_ready}), 32'b100);
      ack(16'hDEAD);
      chk("perr_stale_ack", 32'({nec_ready, nec_ad_oe}), 32'b00);
      push_req(20'h00300, 1'b0, 1'b0, 2'b11, 16'h0000);
      push_resp(1'b1, 1'b1, 16'h4321, 1'b0);
      nec_rd_n = 1'b0;
      wait_req();
      repeat (3) tick();
      ack(16'h4321);
      nec_rd_n = 1'b1;
      tick();
      tick();

      // Reset in RESP during a read, then a clean write.
      push_req(20'h00400, 1'b0, 1'b0, 2'b11, 16'h0000);
      push_resp(1'b1, 1'b1, 16'hC0DE, 1'b0);
      cpu_addr(20'h00400, 1'b1, 1'b0);
      nec_rd_n = 1'b0;
      wait_req();
      repeat (2) tick();
      ack(16'hC0DE);
      reset = 1'b1;
      tick();
      chk("rst_mid_state", 32'({nec_ad_oe, nec_ready, bus_req}), 32'b010);
      reset    = 1'b0;
      nec_rd_n = 1'b1;
      tick();
      push_req(20'h00402, 1'b0, 1'b1, 2'b01, 16'h00A5);
      push_resp(1'b0, 1'b0, 16'h0000, 1'b0);
      cpu_addr(20'h00402, 1'b1, 1'b1);
      nec_ad_in = 20'h000A5;
      nec_wr_n  = 1'b0;
      wait_req();
      tick();
      ack(16'h0000);
      nec_wr_n = 1'b1;
      tick();
      tick();
      chk("post_rst_ready", 32'(nec_ready), 32'd1);

`ifndef NEC_INTA_VECTOR_EN
      // INTAK cycle: back to IDLE with READY high and no request.
      push_resp(1'b0, 1'b0, 16'h0000, 1'b0);
      cpu_addr(20'h00000, 1'b1, 1'b1);
      nec_intak_n = 1'b0;
      tick();
      tick();
      chk("intak_ready", 32'({nec_ready, bus_req, nec_ad_oe}), 32'b100);
      nec_intak_n = 1'b1;
      tick();
      tick();
`endif

      chk("perr_count", 32'(perr_cnt), 32'd1);
      chk("timeout_count", 32'(to_cnt), 32'd1);
      chk("req_queue_empty", 32'(exp_req.size()), 32'd0);
      chk("resp_queue_empty", 32'(exp_resp.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
